// File: rtl/extbus_pkg.sv
// Shared types and constants for the external pad bus arbiter/sequencer.
package extbus_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;
    localparam int BUS_W      = 8;
    localparam int NBA        = DEF_ADDR_W / BUS_W;
    localparam int NBD        = DEF_DATA_W / BUS_W;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CMD,
        DATA,
        DONE
    } state_t;

    // Command byte: bit 0 set marks a write, clear marks a read.
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h00;

    function automatic logic [7:0] cmd_byte(input logic rw);
        return rw ? CMD_READ : CMD_WRITE;
    endfunction

endpackage

// File: rtl/extbus_arb_seq_if.sv
// Requester-side handshake plus pad-side byte bus of the external bus sequencer.
interface extbus_arb_seq_if #(
    parameter int ADDR_W = extbus_pkg::DEF_ADDR_W,
    parameter int DATA_W = extbus_pkg::DEF_DATA_W,
    parameter int BUS_W  = extbus_pkg::BUS_W
);
    logic [1:0]        req_i;
    logic [1:0]        rw_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [1:0]        gnt_o;
    logic [1:0]        done_o;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o;
    logic [BUS_W-1:0]  pad_addr_o;
    logic [BUS_W-1:0]  pad_dout_o;
    logic [BUS_W-1:0]  pad_din_i;
    logic [BUS_W-1:0]  pad_oe_o;

    // The sequencer itself.
    modport slave (
        input  req_i, rw_i, addr0_i, addr1_i, wdata0_i, wdata1_i, pad_din_i,
        output gnt_o, done_o, rdata_o, busy_o, pad_addr_o, pad_dout_o, pad_oe_o
    );

    // Requesters and pad side together.
    modport master (
        output req_i, rw_i, addr0_i, addr1_i, wdata0_i, wdata1_i, pad_din_i,
        input  gnt_o, done_o, rdata_o, busy_o, pad_addr_o, pad_dout_o, pad_oe_o
    );
endinterface

// File: rtl/extbus_arb2.sv
// Two-way arbiter: fixed port0 priority, or round-robin when EXTBUS_RR_EN is defined.
module extbus_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);
`ifdef EXTBUS_RR_EN
    // last = 1 means port1 was granted most recently, so port0 wins a tie.
    always_comb begin
        win = '0;
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        win = '0;
        if (req[0]) begin
            win = 2'b01;
        end else if (req[1]) begin
            win = 2'b10;
        end
    end
`endif
endmodule

// File: rtl/extbus_arb_seq.sv
// Arbitrates two requesters onto the byte-wide pad bus and serialises ADDR, CMD, DATA phases.
// EXTBUS_RR_EN selects round-robin arbitration instead of fixed port0 priority.
module extbus_arb_seq #(
    parameter int ADDR_W = extbus_pkg::DEF_ADDR_W,
    parameter int DATA_W = extbus_pkg::DEF_DATA_W,
    parameter int BUS_W  = extbus_pkg::BUS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    extbus_arb_seq_if.slave   bus
);
    import extbus_pkg::*;

    localparam int NBA_L = ADDR_W / BUS_W;
    localparam int NBD_L = DATA_W / BUS_W;
    localparam int NMAX  = (NBA_L > NBD_L) ? NBA_L : NBD_L;
    localparam int IDX_W = (NMAX > 1) ? $clog2(NMAX) : 1;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [1:0]         win_reg;
    logic               rw_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [DATA_W-BUS_W-1:0] shift_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic [1:0]         win;
    logic               last_grant;

    logic [1:0]         gnt, done;
    logic               busy;
    logic [BUS_W-1:0]   pad_addr, pad_dout, pad_oe;

    logic [BUS_W-1:0]   addr_bytes  [NBA_L];
    logic [BUS_W-1:0]   wdata_bytes [NBD_L];

    wire start     = (state_reg == IDLE) && (|bus.req_i);
    wire addr_last = (idx_reg == IDX_W'(NBA_L - 1));
    wire data_last = (idx_reg == IDX_W'(NBD_L - 1));

    extbus_arb2 u_arb (
        .req  (bus.req_i),
        .last (last_grant),
        .win  (win)
    );

`ifdef EXTBUS_RR_EN
    logic last_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b0;
        end else if (start) begin
            last_reg <= win[1];
        end
    end
    assign last_grant = last_reg;
`else
    assign last_grant = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NBA_L; gi++) begin : g_addr_byte
            assign addr_bytes[gi] = addr_reg[gi*BUS_W +: BUS_W];
        end
        for (genvar gi = 0; gi < NBD_L; gi++) begin : g_wdata_byte
            assign wdata_bytes[gi] = wdata_reg[gi*BUS_W +: BUS_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        gnt        = '0;
        done       = '0;
        busy       = (state_reg != IDLE);
        pad_addr   = '0;
        pad_dout   = '0;
        pad_oe     = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ADDR;
                    idx_next   = '0;
                end
            end
            ADDR: begin
                gnt      = win_reg;
                pad_addr = addr_bytes[idx_reg];
                if (int'(idx_reg) < NBD_L) begin
                    pad_dout = wdata_bytes[idx_reg];
                end
                if (addr_last) begin
                    state_next = CMD;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            CMD: begin
                gnt        = win_reg;
                pad_addr   = BUS_W'(cmd_byte(rw_reg));
                state_next = DATA;
                idx_next   = '0;
            end
            DATA: begin
                gnt = win_reg;
                if (data_last) begin
                    state_next = DONE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            DONE: begin
                done       = win_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
        if (gnt != 2'b00) begin
            pad_oe = {BUS_W{~rw_reg}};
        end
    end

    // Read bytes arrive MSB first; the assembled word is published only on the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_reg   <= '0;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            shift_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if (start) begin
                win_reg <= win;
                if (win[1]) begin
                    rw_reg    <= bus.rw_i[1];
                    addr_reg  <= bus.addr1_i;
                    wdata_reg <= bus.wdata1_i;
                end else begin
                    rw_reg    <= bus.rw_i[0];
                    addr_reg  <= bus.addr0_i;
                    wdata_reg <= bus.wdata0_i;
                end
            end
            if (state_reg == DATA && rw_reg) begin
                if (data_last) begin
                    rdata_reg <= {shift_reg, bus.pad_din_i};
                end else begin
                    shift_reg <= {shift_reg[DATA_W-2*BUS_W-1:0], bus.pad_din_i};
                end
            end
        end
    end

    assign bus.gnt_o      = gnt;
    assign bus.done_o     = done;
    assign bus.busy_o     = busy;
    assign bus.rdata_o    = rdata_reg;
    assign bus.pad_addr_o = pad_addr;
    assign bus.pad_dout_o = pad_dout;
    assign bus.pad_oe_o   = pad_oe;

endmodule
